// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: decode handshake, redirect request and instruction memory port.
// master = sequencer side, slave = memory/decode environment.
interface fetch_sequencer_if;
  logic        enable_i;
  logic        ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    input  enable_i, ready_i, redirect_i, redirect_pc_i, mem_data_i,
    output mem_addr_o, valid_o, instr_o, pc_o, busy_o, err_o
  );

  modport slave (
    output enable_i, ready_i, redirect_i, redirect_pc_i, mem_data_i,
    input  mem_addr_o, valid_o, instr_o, pc_o, busy_o, err_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues PC reads to a 1-cycle synchronous memory, delivers words in program order
// through an output register plus one skid entry; issue-to-valid is 2 edges, issue stalls when both entries are spoken for.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ADDR_MAX = 32'd1020
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        err_q, err_d;

  logic        pop;
  logic        issue;
  logic        busy;
  logic        space_ok;
  logic [1:0]  occ;
  logic [31:0] redir_pc;
  logic        redir_bad;

  assign pop       = out_vld_q & bus.ready_i;
  // Entries already committed: buffered words plus the read still coming back.
  assign occ       = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, inflight_q};
  assign space_ok  = (occ - {1'b0, pop}) < 2'd2;
  assign redir_pc  = {bus.redirect_pc_i[31:2], 2'b00};
  assign redir_bad = redir_pc > ADDR_MAX;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect freezes the state for that cycle
  always_comb begin
    state_d = state_q;
    if (!bus.redirect_i) begin
      case (state_q)
        IDLE:    if (bus.enable_i) state_d = RUN;
        RUN:     if (!bus.enable_i) state_d = DRAIN;
        DRAIN: begin
          if (bus.enable_i)     state_d = RUN;
          else if (!inflight_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    case (state_q)
      RUN: begin
        issue = space_ok & ~bus.redirect_i;
        busy  = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      default: begin
        issue = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  // PC, in-flight tracking and the two-entry return buffer
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inflight_d   = 1'b0;
    out_vld_d    = out_vld_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    err_d        = err_q;

    if (bus.redirect_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      pc_d       = redir_bad ? RESET_PC : redir_pc;
      err_d      = err_q | redir_bad;
    end else begin
      if (issue) begin
        inflight_d = 1'b1;
        req_pc_d   = pc_q;
        pc_d       = (pc_q >= ADDR_MAX) ? RESET_PC : pc_q + 32'd4;
      end

      if (!out_vld_q || pop) begin
        // Skid is older than anything returning, so it always goes first.
        if (skid_vld_q) begin
          out_vld_d    = 1'b1;
          out_instr_d  = skid_instr_q;
          out_pc_d     = skid_pc_q;
          skid_vld_d   = inflight_q;
          skid_instr_d = bus.mem_data_i;
          skid_pc_d    = req_pc_q;
        end else if (inflight_q) begin
          out_vld_d   = 1'b1;
          out_instr_d = bus.mem_data_i;
          out_pc_d    = req_pc_q;
        end else begin
          out_vld_d = 1'b0;
        end
      end else if (inflight_q) begin
        skid_vld_d   = 1'b1;
        skid_instr_d = bus.mem_data_i;
        skid_pc_d    = req_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'd0;
      inflight_q   <= 1'b0;
      out_vld_q    <= 1'b0;
      out_instr_q  <= 32'd0;
      out_pc_q     <= 32'd0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      out_vld_q    <= out_vld_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_addr_o = pc_q;
  assign bus.valid_o    = out_vld_q;
  assign bus.instr_o    = out_instr_q;
  assign bus.pc_o       = out_pc_q;
  assign bus.busy_o     = busy;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: two sequencers (default and ADDR_MAX=8) over a synchronous memory image,
// with a scoreboard of expected PCs consumed on every valid/ready handshake.
module tb_fetch_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   pops_a;
  int   pops_b;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  fetch_sequencer_if if_a();
  fetch_sequencer_if if_b();

  fetch_sequencer #(.RESET_PC(32'h0), .ADDR_MAX(32'd1020)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  fetch_sequencer #(.RESET_PC(32'h0), .ADDR_MAX(32'd8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] addr);
    logic [31:0] idx;
    idx = {24'd0, addr[9:2]};
    if (idx == 32'd0) return 32'hA000_00AA;
    return idx * 32'h1000_0011;
  endfunction

  always @(posedge clk) if_a.mem_data_i <= memword(if_a.mem_addr_o);
  always @(posedge clk) if_b.mem_data_i <= memword(if_b.mem_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_a.push_back(start + 32'(4 * i));
  endtask

  task automatic push_b_wrap(input int n);
    for (int i = 0; i < n; i++) exp_b.push_back(32'(4 * (i % 3)));
  endtask

  // Scoreboards: every accepted word must be the next expected PC and its memory word
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && if_a.valid_o && if_a.ready_i) begin
      pops_a++;
      chk("a_queue_has_entry", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        chk("a_pc_order", if_a.pc_o, e);
        chk("a_instr", if_a.instr_o, memword(e));
      end
    end
    if (rst_n && if_b.valid_o && if_b.ready_i) begin
      pops_b++;
      chk("b_queue_has_entry", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        chk("b_pc_order", if_b.pc_o, e);
        chk("b_instr", if_b.instr_o, memword(e));
      end
    end
  end

  initial begin
    int          cnt;
    int          p0;
    logic [31:0] held_pc;
    logic [31:0] addr_rec;

    tests  = 0;
    fails  = 0;
    pops_a = 0;
    pops_b = 0;
    rst_n  = 1'b0;
    if_a.enable_i      = 1'b1;
    if_a.ready_i       = 1'b1;
    if_a.redirect_i    = 1'b0;
    if_a.redirect_pc_i = 32'd0;
    if_b.enable_i      = 1'b0;
    if_b.ready_i       = 1'b0;
    if_b.redirect_i    = 1'b0;
    if_b.redirect_pc_i = 32'd0;
    push_a(32'h0, 200);

    #2;
    chk("rst_valid", 32'(if_a.valid_o), 32'd0);
    chk("rst_instr", if_a.instr_o, 32'd0);
    chk("rst_pc", if_a.pc_o, 32'd0);
    chk("rst_busy", 32'(if_a.busy_o), 32'd0);
    chk("rst_err", 32'(if_a.err_o), 32'd0);
    chk("rst_mem_addr", if_a.mem_addr_o, 32'd0);

    // Fill after reset: IDLE->RUN, issue, then the word lands
    #1 rst_n = 1'b1;
    cnt = 0;
    while (!if_a.valid_o && cnt < 6) begin
      step(1);
      cnt++;
    end
    chk("first_valid_latency", 32'(cnt >= 2 && cnt <= 3), 32'd1);
    chk("first_pc", if_a.pc_o, 32'h0);
    chk("first_instr", if_a.instr_o, 32'hA000_00AA);
    for (int i = 0; i < 3; i++) begin
      chk("stream_no_gap", 32'(if_a.valid_o), 32'd1);
      step(1);
    end

    // Stall: output holds, skid fills, issue stops
    if_a.ready_i = 1'b0;
    held_pc  = exp_a[0];
    addr_rec = if_a.mem_addr_o;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("hold_valid", 32'(if_a.valid_o), 32'd1);
      chk("hold_pc", if_a.pc_o, held_pc);
      chk("hold_instr", if_a.instr_o, memword(held_pc));
    end
    chk("no_issue_when_full", if_a.mem_addr_o, addr_rec);
    if_a.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("release_no_gap", 32'(if_a.valid_o), 32'd1);
      step(1);
    end

    // Redirect to 0x22 while a read is in flight
    if_a.redirect_i    = 1'b1;
    if_a.redirect_pc_i = 32'h0000_0022;
    step(1);
    if_a.redirect_i = 1'b0;
    exp_a.delete();
    push_a(32'h20, 100);
    chk("redir_edge1_valid", 32'(if_a.valid_o), 32'd0);
    step(1);
    chk("redir_edge2_valid", 32'(if_a.valid_o), 32'd0);
    step(1);
    chk("redir_edge3_valid", 32'(if_a.valid_o), 32'd1);
    chk("redir_pc", if_a.pc_o, 32'h20);
    chk("redir_instr", if_a.instr_o, 32'h8000_0088);
    chk("redir_err", 32'(if_a.err_o), 32'd0);
    step(3);

    // Illegal target wraps to RESET_PC and sets sticky error
    if_a.redirect_i    = 1'b1;
    if_a.redirect_pc_i = 32'h0000_1000;
    step(1);
    if_a.redirect_i = 1'b0;
    exp_a.delete();
    push_a(32'h0, 100);
    chk("bad_redir_err", 32'(if_a.err_o), 32'd1);
    step(2);
    chk("bad_redir_valid", 32'(if_a.valid_o), 32'd1);
    chk("bad_redir_pc", if_a.pc_o, 32'h0);
    chk("bad_redir_instr", if_a.instr_o, 32'hA000_00AA);
    step(4);
    chk("err_sticky", 32'(if_a.err_o), 32'd1);

    // Drain: last issue is still delivered, then IDLE
    if_a.enable_i = 1'b0;
    step(1);
    chk("drain_busy_e1", 32'(if_a.busy_o), 32'd1);
    addr_rec = if_a.mem_addr_o;
    step(1);
    chk("drain_busy_e2", 32'(if_a.busy_o), 32'd1);
    step(1);
    chk("drain_idle", 32'(if_a.busy_o), 32'd0);
    step(3);
    chk("drain_no_issue", if_a.mem_addr_o, addr_rec);
    chk("drain_empty", 32'(if_a.valid_o), 32'd0);
    chk("drain_next_pc", if_a.mem_addr_o, exp_a[0]);
    p0 = pops_a;
    if_a.enable_i = 1'b1;
    step(6);
    chk("resume_delivers", 32'(pops_a - p0 >= 3), 32'd1);

    // Small wrap on the second instance with a patterned ready
    if_a.enable_i = 1'b0;
    step(4);
    push_b_wrap(90);
    if_b.enable_i = 1'b1;
    p0 = pops_b;
    for (int i = 0; i < 20; i++) begin
      if_b.ready_i = (i % 3 != 2);
      step(1);
    end
    chk("wrap_delivers", 32'(pops_b - p0 >= 5), 32'd1);

    // Reset mid-stream
    if_b.ready_i = 1'b1;
    step(2);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_valid_b", 32'(if_b.valid_o), 32'd0);
    chk("midrst_busy_b", 32'(if_b.busy_o), 32'd0);
    chk("midrst_pc_b", if_b.mem_addr_o, 32'h0);
    chk("midrst_valid_a", 32'(if_a.valid_o), 32'd0);
    #2;
    exp_a.delete();
    exp_b.delete();
    push_b_wrap(30);
    rst_n = 1'b1;
    p0 = pops_b;
    step(10);
    chk("restart_delivers", 32'(pops_b - p0 >= 6), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
